// File: rtl/rf_pkg.sv
// rf_pkg: shared rename types and defaults for the Decoder, ROB and rename_rf.
package rf_pkg;
    localparam int TAG_W   = 4;
    localparam int RF_XLEN = 32;
    localparam int RF_NREG = 32;
    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] tag;
    } rf_dep_t;
endpackage

// File: rtl/rf_ckpt_bank.sv
// rf_ckpt_bank: per-branch snapshots of the rename dependency table, kept current by commits.
module rf_ckpt_bank
    import rf_pkg::*;
#(
    parameter int NREG  = RF_NREG,
    parameter int NCKPT = 4,
    localparam int RW = $clog2(NREG),
    localparam int CW = (NCKPT > 1) ? $clog2(NCKPT) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 save,
    input  logic [CW-1:0]        id,
    input  rf_dep_t [NREG-1:0]   save_tbl,
    input  logic                 cmt_vld,
    input  logic [RW-1:0]        cmt_rd,
    input  logic [TAG_W-1:0]     cmt_tag,
    output rf_dep_t [NREG-1:0]   rd_tbl
);
    rf_dep_t [NCKPT-1:0][NREG-1:0] slot_q;

    assign rd_tbl = slot_q[id];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            slot_q <= '0;
        end else if (rdy_in) begin
            for (int s = 0; s < NCKPT; s++) begin
                if (save && id == CW'(s))
                    slot_q[s] <= save_tbl;
                else if (cmt_vld && slot_q[s][cmt_rd].tag == cmt_tag)
                    slot_q[s][cmt_rd].busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/rename_rf.sv
// rename_rf: architectural register file with rename-tag tracking and bypassed reads.
// Define RF_CKPT_EN to build per-branch tag-table checkpoints; otherwise restore acts as a flush.
module rename_rf
    import rf_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int NREG  = RF_NREG,
    parameter int NRD   = 2,
    parameter int NCKPT = 4,
    localparam int RW = $clog2(NREG),
    localparam int CW = (NCKPT > 1) ? $clog2(NCKPT) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 ren_vld,
    input  logic [RW-1:0]        ren_rd,
    input  logic [TAG_W-1:0]     ren_tag,
    input  logic                 cmt_vld,
    input  logic [RW-1:0]        cmt_rd,
    input  logic [TAG_W-1:0]     cmt_tag,
    input  logic [XLEN-1:0]      cmt_val,
    input  logic                 ckpt_save,
    input  logic                 ckpt_restore,
    input  logic [CW-1:0]        ckpt_id,
    input  logic [NRD*RW-1:0]    rd_id,
    output logic [NRD*XLEN-1:0]  rd_val,
    output logic [NRD*TAG_W-1:0] rd_tag,
    output logic [NRD-1:0]       rd_busy
);
    logic [NREG-1:0][XLEN-1:0] val_q;
    rf_dep_t [NREG-1:0]        dep_q, dep_nxt;
    logic                      cm, rn, clr_all;

    assign cm = cmt_vld && cmt_rd != '0;
    assign rn = ren_vld && ren_rd != '0;

`ifdef RF_CKPT_EN
    rf_dep_t [NREG-1:0] ckpt_tbl;

    assign clr_all = flush_in;

    rf_ckpt_bank #(.NREG(NREG), .NCKPT(NCKPT)) u_bank (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .save     (ckpt_save && !ckpt_restore),
        .id       (ckpt_id),
        .save_tbl (dep_nxt),
        .cmt_vld  (cm),
        .cmt_rd   (cmt_rd),
        .cmt_tag  (cmt_tag),
        .rd_tbl   (ckpt_tbl)
    );
`else
    logic unused_ckpt;

    assign clr_all     = flush_in || ckpt_restore;
    assign unused_ckpt = ^{ckpt_save, ckpt_id};
`endif

    always_comb begin
        dep_nxt = dep_q;
        if (clr_all) begin
            dep_nxt = '0;
`ifdef RF_CKPT_EN
        end else if (ckpt_restore) begin
            dep_nxt = ckpt_tbl;
            if (cm && ckpt_tbl[cmt_rd].tag == cmt_tag) dep_nxt[cmt_rd].busy = 1'b0;
`endif
        end else begin
            if (cm && dep_q[cmt_rd].tag == cmt_tag) dep_nxt[cmt_rd].busy = 1'b0;
            if (rn) dep_nxt[ren_rd] = '{busy: 1'b1, tag: ren_tag};
        end
        dep_nxt[0] = '0;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dep_q <= '0;
            val_q <= '0;
        end else if (rdy_in) begin
            dep_q <= dep_nxt;
            if (cm) val_q[cmt_rd] <= cmt_val;
        end
    end

    // Register 0 is never written, so only the bypass paths need an explicit x0 guard.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [RW-1:0] a;
        logic          ren_hit, cmt_hit;
        assign a       = rd_id[k*RW +: RW];
        assign ren_hit = !rst_in && rn && ren_rd == a;
        assign cmt_hit = !rst_in && cm && cmt_rd == a;
        assign rd_val[k*XLEN +: XLEN]   = cmt_hit ? cmt_val : val_q[a];
        assign rd_tag[k*TAG_W +: TAG_W] = ren_hit ? ren_tag : dep_q[a].tag;
        assign rd_busy[k] = ren_hit || (dep_q[a].busy && !(cmt_hit && dep_q[a].tag == cmt_tag));
    end
endmodule

// File: tb/tb_rename_rf.sv
// tb_rename_rf: directed plus randomized checks of rename_rf against an array-based model.
module tb_rename_rf;
    import rf_pkg::*;

    localparam int NRD = 2;
`ifdef RF_CKPT_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, flush_in = 1'b0;
    logic        ren_vld = 1'b0, cmt_vld = 1'b0, ckpt_save = 1'b0, ckpt_restore = 1'b0;
    logic [4:0]  ren_rd = '0, cmt_rd = '0;
    logic [3:0]  ren_tag = '0, cmt_tag = '0;
    logic [31:0] cmt_val = '0;
    logic [1:0]  ckpt_id = '0;
    logic [9:0]  rd_id = '0;
    logic [63:0] rd_val;
    logic [7:0]  rd_tag;
    logic [1:0]  rd_busy;

    int n_chk = 0, n_fail = 0;

    logic [31:0] mval[32];
    logic [3:0]  mtag[32];
    bit          mbusy[32];
    logic [3:0]  ck_tag[4][32];
    bit          ck_busy[4][32];

    rename_rf dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .ren_vld(ren_vld), .ren_rd(ren_rd), .ren_tag(ren_tag),
        .cmt_vld(cmt_vld), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_val(cmt_val),
        .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore), .ckpt_id(ckpt_id),
        .rd_id(rd_id), .rd_val(rd_val), .rd_tag(rd_tag), .rd_busy(rd_busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            mval[r] = '0; mtag[r] = '0; mbusy[r] = 0;
            for (int s = 0; s < 4; s++) begin ck_tag[s][r] = '0; ck_busy[s][r] = 0; end
        end
    endtask

    // One clock of architectural behaviour, applied from the inputs held across the edge.
    task automatic model_step();
        bit         cm, rn;
        logic [3:0] t_tag[32];
        bit         t_busy[32];
        if (rst_in) begin model_clear(); return; end
        if (!rdy_in) return;
        cm = cmt_vld && cmt_rd != 0;
        rn = ren_vld && ren_rd != 0;
        for (int r = 0; r < 32; r++) begin t_tag[r] = mtag[r]; t_busy[r] = mbusy[r]; end
        if (flush_in || (!CK && ckpt_restore)) begin
            for (int r = 0; r < 32; r++) begin t_tag[r] = '0; t_busy[r] = 0; end
        end else if (ckpt_restore) begin
            for (int r = 0; r < 32; r++) begin t_tag[r] = ck_tag[ckpt_id][r]; t_busy[r] = ck_busy[ckpt_id][r]; end
            if (cm && t_tag[cmt_rd] == cmt_tag) t_busy[cmt_rd] = 0;
        end else begin
            if (cm && mtag[cmt_rd] == cmt_tag && !(rn && ren_rd == cmt_rd)) t_busy[cmt_rd] = 0;
            if (rn) begin t_tag[ren_rd] = ren_tag; t_busy[ren_rd] = 1; end
        end
        if (CK) begin
            for (int s = 0; s < 4; s++)
                if (cm && ck_tag[s][cmt_rd] == cmt_tag) ck_busy[s][cmt_rd] = 0;
            if (ckpt_save && !ckpt_restore)
                for (int r = 0; r < 32; r++) begin ck_tag[ckpt_id][r] = t_tag[r]; ck_busy[ckpt_id][r] = t_busy[r]; end
        end
        if (cm) mval[cmt_rd] = cmt_val;
        for (int r = 0; r < 32; r++) begin mtag[r] = t_tag[r]; mbusy[r] = t_busy[r]; end
    endtask

    task automatic step();
        @(posedge clk_in);
        model_step();
        #1;
    endtask

    task automatic idle();
        ren_vld = 0; cmt_vld = 0; flush_in = 0; ckpt_save = 0; ckpt_restore = 0; rdy_in = 1;
    endtask

    // Continuous comparison of every read port against the model, mid-cycle.
    always @(negedge clk_in) begin
        logic [4:0]  a;
        logic [31:0] ev;
        logic [3:0]  et;
        bit          eb, rh, ch;
        for (int k = 0; k < NRD; k++) begin
            a  = rd_id[k*5 +: 5];
            rh = !rst_in && ren_vld && ren_rd == a && a != 0;
            ch = !rst_in && cmt_vld && cmt_rd == a && a != 0;
            if (rst_in || a == 0) begin
                ev = '0; et = '0; eb = 0;
            end else begin
                ev = ch ? cmt_val : mval[a];
                et = rh ? ren_tag : mtag[a];
                eb = rh ? 1'b1 : (ch && mtag[a] == cmt_tag) ? 1'b0 : mbusy[a];
            end
            chk($sformatf("rd_val[%0d] x%0d", k, a), 64'(rd_val[k*32 +: 32]), 64'(ev));
            chk($sformatf("rd_tag[%0d] x%0d", k, a), 64'(rd_tag[k*4 +: 4]), 64'(et));
            chk($sformatf("rd_busy[%0d] x%0d", k, a), 64'(rd_busy[k]), 64'(eb));
        end
    end

    initial begin
        model_clear();
        rd_id = {5'd5, 5'd5};
        #2;
        chk("reset_val", 64'(rd_val), 64'd0);
        chk("reset_tag", 64'(rd_tag), 64'd0);
        chk("reset_busy", 64'(rd_busy), 64'd0);
        step();
        rst_in = 0;

        cmt_vld = 1; cmt_rd = 0; cmt_tag = 0; cmt_val = 32'hDEAD; rd_id = {5'd0, 5'd0};
        #1 chk("x0_bypass", 64'(rd_val[31:0]), 64'd0);
        step(); idle();
        #1 chk("x0_stored", 64'(rd_val[31:0]), 64'd0);

        ren_vld = 1; ren_rd = 3; ren_tag = 7; rd_id = {5'd3, 5'd3};
        step(); idle();
        cmt_vld = 1; cmt_rd = 3; cmt_tag = 7; cmt_val = 32'h1234;
        #1;
        chk("x3_cmt_cycle_busy", 64'(rd_busy[0]), 64'd0);
        chk("x3_cmt_cycle_val", 64'(rd_val[31:0]), 64'h1234);
        step(); idle();
        #1;
        chk("x3_after_busy", 64'(rd_busy[1]), 64'd0);
        chk("x3_after_val", 64'(rd_val[63:32]), 64'h1234);
        chk("model_x3_val", 64'(mval[3]), 64'h1234);

        ren_vld = 1; ren_rd = 3; ren_tag = 2; step();
        ren_tag = 5; step(); idle();
        cmt_vld = 1; cmt_rd = 3; cmt_tag = 2; cmt_val = 9; step(); idle();
        #1;
        chk("x3_stale_val", 64'(rd_val[31:0]), 64'd9);
        chk("x3_stale_busy", 64'(rd_busy[0]), 64'd1);
        chk("x3_stale_tag", 64'(rd_tag[3:0]), 64'd5);

        ren_vld = 1; ren_rd = 4; ren_tag = 6; rd_id = {5'd4, 5'd4}; step();
        cmt_vld = 1; cmt_rd = 4; cmt_tag = 6; cmt_val = 32'h77; step(); idle();
        #1;
        chk("x4_ren_cmt_busy", 64'(rd_busy[0]), 64'd1);
        chk("x4_ren_cmt_tag", 64'(rd_tag[3:0]), 64'd6);
        chk("x4_ren_cmt_val", 64'(rd_val[31:0]), 64'h77);

        ren_vld = 1; ren_rd = 1; ren_tag = 1; step();
        ren_rd = 2; ren_tag = 2; step();
        ren_rd = 9; ren_tag = 3; flush_in = 1;
        cmt_vld = 1; cmt_rd = 7; cmt_tag = 0; cmt_val = 32'h55; step(); idle();
        rd_id = {5'd2, 5'd1};
        #1 chk("flush_busy12", 64'(rd_busy), 64'd0);
        rd_id = {5'd9, 5'd7};
        #1;
        chk("flush_x7_val", 64'(rd_val[31:0]), 64'h55);
        chk("flush_x9_dropped", 64'(rd_busy[1]), 64'd0);

        ren_vld = 1; ren_rd = 8; ren_tag = 3; rd_id = {5'd8, 5'd8}; step(); idle();
        ckpt_save = 1; ckpt_id = 1; step(); idle();
        ren_vld = 1; ren_rd = 8; ren_tag = 4; step(); idle();
        cmt_vld = 1; cmt_rd = 8; cmt_tag = 3; cmt_val = 32'h88; step(); idle();
        #1 chk("x8_pre_restore_busy", 64'(rd_busy[0]), 64'd1);
        ckpt_restore = 1; ckpt_id = 1; step(); idle();
        #1;
        chk("x8_restore_busy", 64'(rd_busy[0]), 64'd0);
        chk("model_x8_busy", 64'(mbusy[8]), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            rdy_in       = $urandom_range(0, 9) != 0;
            flush_in     = $urandom_range(0, 29) == 0;
            ckpt_restore = $urandom_range(0, 24) == 0;
            ckpt_save    = $urandom_range(0, 7) == 0;
            ckpt_id      = 2'($urandom);
            ren_vld      = 1'($urandom);
            ren_rd       = 5'($urandom_range(0, 9));
            ren_tag      = 4'($urandom);
            cmt_vld      = 1'($urandom);
            cmt_rd       = 5'($urandom_range(0, 9));
            cmt_tag      = $urandom_range(0, 1) ? mtag[cmt_rd] : 4'($urandom);
            cmt_val      = $urandom;
            rd_id[4:0]   = $urandom_range(0, 2) == 0 ? cmt_rd : 5'($urandom_range(0, 9));
            rd_id[9:5]   = $urandom_range(0, 2) == 0 ? ren_rd : 5'($urandom_range(0, 31));
            if (i == 1500) begin
                #2 rst_in = 1;
                #1;
                chk("async_rst_val", 64'(rd_val), 64'd0);
                chk("async_rst_tag", 64'(rd_tag), 64'd0);
                chk("async_rst_busy", 64'(rd_busy), 64'd0);
                model_clear();
                @(posedge clk_in);
                #1 rst_in = 0;
            end else begin
                step();
            end
        end
        idle();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rename_rf.md
# rename_rf

Parametrised architectural register file with rename-tag tracking for the out-of-order core. It sits between the Decoder, which renames destinations and reads operands, and the ROB, which commits results and flushes. It generalises the single-table design in three ways: any number of read ports, configurable register count and widths, and optional per-branch checkpoints of the tag table. Checkpoints let a mispredict restore dependencies selectively instead of clearing them all.

## Interface
- XLEN, 32, data width
- NREG, 32, number of architectural registers (power of 2, ≥2)
- TAG_W, 4, ROB tag width
- NRD, 2, number of operand read ports
- NCKPT, 4, number of checkpoints (power of 2; used only with RF_CKPT_EN)
- clk_in  in  1  clock
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  global enable; low freezes all state
- flush_in  in  1  full pipeline flush from ROB
- ren_vld  in  1  rename request from Decoder
- ren_rd  in  log2(NREG)  destination register
- ren_tag  in  TAG_W  ROB tag assigned to ren_rd
- cmt_vld  in  1  commit from ROB
- cmt_rd  in  log2(NREG)  committed destination
- cmt_tag  in  TAG_W  tag of committing entry
- cmt_val  in  XLEN  committed value
- ckpt_save  in  1  snapshot the tag table into slot ckpt_id
- ckpt_restore  in  1  restore the tag table from slot ckpt_id
- ckpt_id  in  log2(NCKPT)  checkpoint slot
- rd_id  in  NRD*log2(NREG)  packed read addresses
- rd_val  out  NRD*XLEN  packed operand values
- rd_tag  out  NRD*TAG_W  packed producer tags
- rd_busy  out  NRD  1 = operand pending, wait on rd_tag

## Operation
- State per register: val[XLEN], tag[TAG_W], busy. Register 0 reads val=0 and busy=0 in all cases. Writes, renames and commits to register 0 are ignored.
- Commit: val[cmt_rd] <= cmt_val unconditionally. busy[cmt_rd] <= 0 only when tag[cmt_rd]==cmt_tag and there is no same-cycle rename of the same register.
- Rename: tag[ren_rd] <= ren_tag and busy[ren_rd] <= 1. A rename wins over a same-cycle commit on the same register.
- Flush: every busy bit <= 0 and every tag <= 0. Values are kept. A same-cycle commit value write still applies. A same-cycle rename is dropped.
- Read port k is combinational, with bypass priority:
  - rename to rd_id[k] this cycle: busy=1, tag=ren_tag.
  - otherwise, a matching-tag commit to rd_id[k]: busy=0.
  - otherwise: stored state.
- rd_val bypasses cmt_val whenever cmt_vld && cmt_rd==rd_id[k], otherwise it returns stored val.
- rdy_in low: no state changes. Reads remain live.
- Simultaneous save and restore on the same id: restore wins and no save occurs.

## Timing
- Reads: 0-cycle latency. Updates land on the next posedge and are visible the same cycle through bypass.
- Reset (asynchronous): all val=0, tag=0, busy=0, every checkpoint cleared. rd_val/rd_tag/rd_busy read 0 immediately.
- Reset asserted mid-operation discards all pending renames and checkpoints.
- Priority per cycle: reset > flush > restore > (rename, commit).

## Configuration
- RF_CKPT_EN defined:
  - ckpt_save captures the post-cycle tag/busy table, including that cycle's rename and commit, into slot ckpt_id.
  - ckpt_restore loads slot ckpt_id, with the same-cycle commit's busy-clear applied to the restored table. A same-cycle rename is dropped.
  - Every commit also clears busy in every stored slot whose entry tag for cmt_rd equals cmt_tag.
- RF_CKPT_EN undefined: checkpoint storage is not built. ckpt_save is ignored. ckpt_restore behaves exactly like flush_in. Ports stay present.

## Structure
- Package rf_pkg: TAG_W, the default XLEN/NREG, and the typedef rf_dep_t {busy, tag}. ROB and Decoder share this package.
- Sub-module rf_ckpt_bank: NCKPT×NREG rf_dep_t storage with save, restore and commit-clear logic. Instantiated only under RF_CKPT_EN.

## Test plan
- Reset, then read x5 on both ports -> val=0, busy=0, tag=0. Commit x0=0xDEAD -> x0 still reads 0.
- Rename x3 tag 7; next cycle commit x3 tag 7 val 0x1234 -> busy clears, val=0x1234. In the commit cycle the read already shows busy=0 and val 0x1234.
- Rename x3 tag 2, then rename x3 tag 5, then commit x3 tag 2 val 9 -> val=9, busy stays 1, tag=5.
- Same cycle: rename x4 tag 6 and matching-tag commit x4 -> next cycle busy=1, tag=6, new value stored.
- Rename x1/x2 with tags 1/2, then flush with a concurrent commit x7=0x55 -> all busy 0, x7=0x55, same-cycle rename dropped.
- RF_CKPT_EN: rename x8 tag 3, save slot 1, rename x8 tag 4, commit x8 tag 3, restore slot 1 -> x8 busy=0. Without the macro, the same sequence leaves all busy=0 after restore.
